// File: rtl/fft16_iter_sequencer.sv
// Control sequencer for the 16-point iterative radix-2 FFT/IFFT core.
// Walks bit-reversed load, LOG2N butterfly stages with drain, then done.
module fft16_iter_sequencer #(
  parameter int N      = 16,
  parameter int LOG2N  = 4,
  parameter int BF_LAT = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     mode,
  output logic                     busy,
  output logic                     done,
  output logic                     ld_en,
  output logic [LOG2N-1:0]         ld_idx,
  output logic [LOG2N-1:0]         ld_addr,
  output logic                     bf_valid,
  output logic [LOG2N-1:0]         bf_addr_a,
  output logic [LOG2N-1:0]         bf_addr_b,
  output logic [LOG2N-2:0]         tw_idx,
  output logic                     tw_conj,
  output logic [$clog2(LOG2N)-1:0] stage,
  output logic                     wb_en,
  output logic [LOG2N-1:0]         wb_addr_a,
  output logic [LOG2N-1:0]         wb_addr_b
);

  localparam int KW = LOG2N - 1;
  localparam int SW = $clog2(LOG2N);
  localparam int DW = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;
  localparam int PW = 2 * LOG2N + 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ISSUE,
    DRAIN,
    FIN
  } state_t;

  state_t        state;
  logic [KW-1:0] k;
  logic [DW-1:0] dcnt;

  logic [LOG2N-1:0] ld_nxt;
  logic [KW-1:0]    k_nxt;
  logic [SW-1:0]    stg_nxt;

  assign ld_nxt  = ld_idx + 1'b1;
  assign k_nxt   = k + 1'b1;
  assign stg_nxt = stage + 1'b1;

  function automatic logic [LOG2N-1:0] bitrev(
    input logic [LOG2N-1:0] x
  );
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++)
      r[i] = x[LOG2N-1-i];
    return r;
  endfunction

  function automatic logic [LOG2N-1:0] half_of(
    input logic [SW-1:0] s
  );
    return LOG2N'(1) << s;
  endfunction

  // Top operand: group base (k>>s)*2*half plus offset within group.
  function automatic logic [LOG2N-1:0] addr_a(
    input logic [KW-1:0] kv,
    input logic [SW-1:0] s
  );
    logic [LOG2N-1:0] kk, lo, hi;
    kk = {1'b0, kv};
    lo = kk & (half_of(s) - LOG2N'(1));
    hi = (kk >> s) << (int'(s) + 1);
    return hi | lo;
  endfunction

  // Twiddle exponent scales the in-group offset up to the N-point grid.
  function automatic logic [KW-1:0] twid(
    input logic [KW-1:0] kv,
    input logic [SW-1:0] s
  );
    logic [KW-1:0] lo;
    lo = kv & ((KW'(1) << s) - KW'(1));
    return lo << (KW - int'(s));
  endfunction

  // Main sequencer; every output is registered from next-state values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      ld_en     <= 1'b0;
      ld_idx    <= '0;
      ld_addr   <= '0;
      bf_valid  <= 1'b0;
      bf_addr_a <= '0;
      bf_addr_b <= '0;
      tw_idx    <= '0;
      tw_conj   <= 1'b0;
      stage     <= '0;
      k         <= '0;
      dcnt      <= '0;
    end else begin
      done     <= 1'b0;
      ld_en    <= 1'b0;
      bf_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state   <= LOAD;
            busy    <= 1'b1;
            tw_conj <= mode;
            ld_en   <= 1'b1;
            ld_idx  <= '0;
            ld_addr <= '0;
          end
        end
        LOAD: begin
          if (ld_idx == LOG2N'(N - 1)) begin
            state     <= ISSUE;
            ld_idx    <= '0;
            ld_addr   <= '0;
            stage     <= '0;
            k         <= '0;
            bf_valid  <= 1'b1;
            bf_addr_a <= addr_a('0, '0);
            bf_addr_b <= addr_a('0, '0)
                         + half_of('0);
            tw_idx    <= twid('0, '0);
          end else begin
            ld_en   <= 1'b1;
            ld_idx  <= ld_nxt;
            ld_addr <= bitrev(ld_nxt);
          end
        end
        ISSUE: begin
          if (k == KW'(N / 2 - 1)) begin
            state <= DRAIN;
            dcnt  <= '0;
          end else begin
            k         <= k_nxt;
            bf_valid  <= 1'b1;
            bf_addr_a <= addr_a(k_nxt, stage);
            bf_addr_b <= addr_a(k_nxt, stage)
                         + half_of(stage);
            tw_idx    <= twid(k_nxt, stage);
          end
        end
        DRAIN: begin
          if (dcnt == DW'(BF_LAT - 1)) begin
            if (stage == SW'(LOG2N - 1)) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state     <= ISSUE;
              stage     <= stg_nxt;
              k         <= '0;
              bf_valid  <= 1'b1;
              bf_addr_a <= addr_a('0, stg_nxt);
              bf_addr_b <= addr_a('0, stg_nxt)
                           + half_of(stg_nxt);
              tw_idx    <= twid('0, stg_nxt);
            end
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
          stage <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [PW-1:0] pipe [BF_LAT];

  // Write-back strobe/addresses trail issue by exactly BF_LAT cycles.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < BF_LAT; i++)
        pipe[i] <= '0;
    end else begin
      pipe[0] <= {bf_valid, bf_addr_a, bf_addr_b};
      for (int i = 1; i < BF_LAT; i++)
        pipe[i] <= pipe[i-1];
    end
  end

  assign {wb_en, wb_addr_a, wb_addr_b} = pipe[BF_LAT-1];

endmodule

// File: tb/tb_fft16_iter_sequencer.sv
// Bench for fft16_iter_sequencer: per-cycle scoreboard of
// expected outputs built from an independent model of the schedule.
module tb_fft16_iter_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       mode;
  logic       busy, done, ld_en, bf_valid;
  logic       tw_conj, wb_en;
  logic [3:0] ld_idx, ld_addr;
  logic [3:0] bf_addr_a, bf_addr_b;
  logic [2:0] tw_idx;
  logic [1:0] stage;
  logic [3:0] wb_addr_a, wb_addr_b;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       ld_en;
    logic [3:0] ld_idx;
    logic [3:0] ld_addr;
    logic       bf_valid;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] tw;
    logic       conj;
    logic [1:0] stage;
    logic       wb_en;
    logic [3:0] wa;
    logic [3:0] wb;
  } vec_t;

  vec_t q[$];

  fft16_iter_sequencer #(
    .N(16), .LOG2N(4), .BF_LAT(2)
  ) dut (
    .clk(clk), .rst(rst),
    .start(start), .mode(mode),
    .busy(busy), .done(done),
    .ld_en(ld_en), .ld_idx(ld_idx),
    .ld_addr(ld_addr), .bf_valid(bf_valid),
    .bf_addr_a(bf_addr_a),
    .bf_addr_b(bf_addr_b),
    .tw_idx(tw_idx), .tw_conj(tw_conj),
    .stage(stage), .wb_en(wb_en),
    .wb_addr_a(wb_addr_a),
    .wb_addr_b(wb_addr_b)
  );

  always #5 clk = ~clk;

  function automatic vec_t obs_now();
    vec_t v;
    v.busy     = busy;
    v.done     = done;
    v.ld_en    = ld_en;
    v.ld_idx   = ld_idx;
    v.ld_addr  = ld_addr;
    v.bf_valid = bf_valid;
    v.a        = bf_addr_a;
    v.b        = bf_addr_b;
    v.tw       = tw_idx;
    v.conj     = tw_conj;
    v.stage    = stage;
    v.wb_en    = wb_en;
    v.wa       = wb_addr_a;
    v.wb       = wb_addr_b;
    return v;
  endfunction

  // Fields only matter while their strobe is expected high.
  function automatic vec_t msk(vec_t v, vec_t r);
    vec_t o;
    o = v;
    if (!r.ld_en) begin
      o.ld_idx  = '0;
      o.ld_addr = '0;
    end
    if (!r.bf_valid) begin
      o.a = '0; o.b = '0; o.tw = '0;
      o.conj = 1'b0; o.stage = '0;
    end
    if (!r.wb_en) begin
      o.wa = '0; o.wb = '0;
    end
    return o;
  endfunction

  task automatic chk(input string tag,
                     input vec_t ob, input vec_t ex);
    checks++;
    assert (ob === ex) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, ob, ex);
    end
  endtask

  // Expected outputs for cycles 1..58 after start sampled at edge 0.
  task automatic push_run(input logic m);
    vec_t e [59];
    int c, half, av;
    logic [3:0] iv;
    for (int i = 0; i < 59; i++) e[i] = '0;
    for (int i = 1; i <= 57; i++) e[i].busy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      iv = 4'(i);
      e[1+i].ld_en   = 1'b1;
      e[1+i].ld_idx  = iv;
      e[1+i].ld_addr = {iv[0], iv[1], iv[2], iv[3]};
    end
    for (int s = 0; s < 4; s++) begin
      half = 1 << s;
      for (int kk = 0; kk < 8; kk++) begin
        c  = 17 + 10 * s + kk;
        av = (kk / half) * 2 * half + kk % half;
        e[c].bf_valid = 1'b1;
        e[c].a     = 4'(av);
        e[c].b     = 4'(av + half);
        e[c].tw    = 3'((kk % half) * (8 / half));
        e[c].conj  = m;
        e[c].stage = 2'(s);
      end
    end
    for (int i = 3; i < 59; i++) begin
      if (e[i-2].bf_valid) begin
        e[i].wb_en = 1'b1;
        e[i].wa    = e[i-2].a;
        e[i].wb    = e[i-2].b;
      end
    end
    e[57].done = 1'b1;
    for (int i = 1; i < 59; i++) q.push_back(e[i]);
  endtask

  task automatic launch(input logic m);
    @(negedge clk);
    start = 1'b1;
    mode  = m;
    push_run(m);
    @(posedge clk);
  endtask

  task automatic run(input int n, input int p1,
                     input int p2, input bit tog);
    vec_t ex;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      start = (c == p1 || c == p2);
      if (tog) mode = ~mode;
      ex = q.pop_front();
      chk($sformatf("cyc%0d", c),
          msk(obs_now(), ex), ex);
    end
    start = 1'b0;
  endtask

  task automatic idle_chk(input int n, input string tag);
    vec_t z;
    z = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk(tag, msk(obs_now(), z), z);
    end
  endtask

  initial begin
    rst   = 1'b0;
    start = 1'b1;
    mode  = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      chk("reset", obs_now(), '0);
    end
    start = 1'b0;
    rst   = 1'b1;
    idle_chk(2, "post_reset");

    launch(1'b0);
    run(58, 0, 0, 1'b0);
    idle_chk(3, "idle_fft");

    launch(1'b1);
    run(58, 5, 57, 1'b1);
    idle_chk(3, "idle_ifft");

    launch(1'b0);
    run(40, 0, 0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_reset", obs_now(), '0);
    q.delete();
    rst = 1'b1;
    idle_chk(4, "after_mid_reset");

    launch(1'b1);
    run(58, 0, 0, 1'b0);
    idle_chk(2, "final_idle");

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
